// File: rtl/ps2_defs.sv
// ps2_defs: shared PS/2 set-2 scan-code constants and decoder FSM state encoding.
// Used by ps2_key_decoder.
package ps2_defs;

  // Prefix and modifier codes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Digits
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  // Letters
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_Z = 8'h1A;

  // Control keys
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_key_decoder_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO.
// Ports: clock, reset (async, active-high), push/din write side, pop/dout read side,
//        full, empty, count (occupied entries).
// A push while full is accepted only if a pop happens in the same cycle.
// dout is forced to zero while empty so the head reads 0 out of reset.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan-code to ASCII decoder with output FIFO.
// Ports:
//   clock, reset      single clock, async active-high reset
//   scan_code/valid   one received PS/2 byte per strobe
//   ascii/ascii_valid head of output FIFO (show-ahead), ascii_ready pops it
//   fifo_count        occupied FIFO entries
//   shift_active      either shift key held
//   overflow          sticky drop flag, cleared by clr_overflow (set wins)
//
// state      | meaning
// ST_IDLE    | no prefix pending; bytes are make codes or prefixes
// ST_BRK     | F0 seen; next byte is a released key
// ST_EXT     | E0 seen; next byte is an extended key (ignored) or F0
// ST_EXT_BRK | E0 F0 seen; next byte is an extended release (ignored)
import ps2_defs::*;

module ps2_key_decoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter bit         HEX_ONLY   = 1'b1,
  parameter bit         EMIT_ERR   = 1'b1,
  parameter logic [7:0] ERR_CHAR   = 8'h78
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_valid,
  output logic [7:0]                      ascii,
  output logic                            ascii_valid,
  input  logic                            ascii_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            shift_active,
  output logic                            overflow,
  input  logic                            clr_overflow
);

  state_t     state, state_n;
  logic       lshift, lshift_n;
  logic       rshift, rshift_n;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       full;
  logic       empty;

  logic       map_hit;
  logic       map_full_only;
  logic       map_letter;
  logic [7:0] map_char;
  logic       hit;
  logic [7:0] char_out;

  assign shift_active = lshift | rshift;

  // Letters are looked up as uppercase; the full map lowercases them unless shifted.
  always_comb begin
    map_hit       = 1'b1;
    map_full_only = 1'b0;
    map_letter    = 1'b0;
    map_char      = 8'h00;
    case (scan_code)
      SC_0: map_char = 8'h30;
      SC_1: map_char = 8'h31;
      SC_2: map_char = 8'h32;
      SC_3: map_char = 8'h33;
      SC_4: map_char = 8'h34;
      SC_5: map_char = 8'h35;
      SC_6: map_char = 8'h36;
      SC_7: map_char = 8'h37;
      SC_8: map_char = 8'h38;
      SC_9: map_char = 8'h39;
      SC_A: begin map_char = 8'h41; map_letter = 1'b1; end
      SC_B: begin map_char = 8'h42; map_letter = 1'b1; end
      SC_C: begin map_char = 8'h43; map_letter = 1'b1; end
      SC_D: begin map_char = 8'h44; map_letter = 1'b1; end
      SC_E: begin map_char = 8'h45; map_letter = 1'b1; end
      SC_F: begin map_char = 8'h46; map_letter = 1'b1; end
      SC_G: begin map_char = 8'h47; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_H: begin map_char = 8'h48; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_I: begin map_char = 8'h49; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_J: begin map_char = 8'h4A; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_K: begin map_char = 8'h4B; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_L: begin map_char = 8'h4C; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_M: begin map_char = 8'h4D; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_N: begin map_char = 8'h4E; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_O: begin map_char = 8'h4F; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_P: begin map_char = 8'h50; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_Q: begin map_char = 8'h51; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_R: begin map_char = 8'h52; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_S: begin map_char = 8'h53; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_T: begin map_char = 8'h54; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_U: begin map_char = 8'h55; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_V: begin map_char = 8'h56; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_W: begin map_char = 8'h57; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_X: begin map_char = 8'h58; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_Y: begin map_char = 8'h59; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_Z: begin map_char = 8'h5A; map_letter = 1'b1; map_full_only = 1'b1; end
      SC_SPACE: begin map_char = 8'h20; map_full_only = 1'b1; end
      SC_ENTER: begin map_char = 8'h0D; map_full_only = 1'b1; end
      SC_BKSP:  begin map_char = 8'h08; map_full_only = 1'b1; end
      default: map_hit = 1'b0;
    endcase
  end

  assign hit      = map_hit && !(HEX_ONLY && map_full_only);
  assign char_out = (map_letter && !HEX_ONLY && !shift_active) ? (map_char | 8'h20) : map_char;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else begin
      state  <= state_n;
      lshift <= lshift_n;
      rshift <= rshift_n;
    end
  end

  always_comb begin
    state_n   = state;
    lshift_n  = lshift;
    rshift_n  = rshift;
    push      = 1'b0;
    push_data = char_out;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_EXT) begin
            state_n = ST_EXT;
          end else if (scan_code == SC_BREAK) begin
            state_n = ST_BRK;
          end else if (scan_code == SC_LSHIFT) begin
            lshift_n = 1'b1;
          end else if (scan_code == SC_RSHIFT) begin
            rshift_n = 1'b1;
          end else if (hit) begin
            push = 1'b1;
          end else if (EMIT_ERR) begin
            push      = 1'b1;
            push_data = ERR_CHAR;
          end
        end
        ST_BRK: begin
          if (scan_code == SC_LSHIFT) lshift_n = 1'b0;
          else if (scan_code == SC_RSHIFT) rshift_n = 1'b0;
          state_n = ST_IDLE;
        end
        ST_EXT: begin
          state_n = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign ascii_valid = !empty;
  assign pop         = ascii_valid && ascii_ready;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (ascii),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // A same-cycle pop frees the slot, so only a full push without pop drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: two instances (hex-only with error chars, and full map
// without error chars) share stimulus; each is compared every cycle against a
// list-based behavioural model, plus literal expectations for the directed cases.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ascii_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  logic [7:0] d_ascii [2];
  logic       d_valid [2];
  logic [2:0] d_count [2];
  logic       d_shift [2];
  logic       d_ovf   [2];

  int total = 0;
  int bad   = 0;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .HEX_ONLY(1'b1), .EMIT_ERR(1'b1), .ERR_CHAR(8'h78)) dut_a (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii(d_ascii[0]), .ascii_valid(d_valid[0]), .ascii_ready(ascii_ready),
    .fifo_count(d_count[0]), .shift_active(d_shift[0]), .overflow(d_ovf[0]),
    .clr_overflow(clr_overflow));

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .HEX_ONLY(1'b0), .EMIT_ERR(1'b0), .ERR_CHAR(8'h78)) dut_b (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .ascii(d_ascii[1]), .ascii_valid(d_valid[1]), .ascii_ready(ascii_ready),
    .fifo_count(d_count[1]), .shift_active(d_shift[1]), .overflow(d_ovf[1]),
    .clr_overflow(clr_overflow));

  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Set-2 code tables, in character order
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic int map_code(input logic [7:0] c, input bit hex, input bit shift);
    for (int i = 0; i < 10; i++) if (c == dig_codes[i]) return 'h30 + i;
    for (int i = 0; i < 26; i++) begin
      if (c == let_codes[i]) begin
        if (hex && i > 5) return -1;
        return (hex || shift) ? 'h41 + i : 'h61 + i;
      end
    end
    if (!hex) begin
      if (c == 8'h29) return 'h20;
      if (c == 8'h5A) return 'h0D;
      if (c == 8'h66) return 'h08;
    end
    return -1;
  endfunction

  // Model: FIFO kept as an ordered list (index 0 = head), prefix as a byte list.
  logic [7:0] mf   [2][DEPTH];
  int         mcnt [2];
  bit         ml   [2];
  bit         mr   [2];
  bit         movf [2];
  logic [7:0] mpre [2];
  int         mplen[2];

  task automatic model_step(input int k);
    bit hex  = (k == 0);
    bit err  = (k == 0);
    bit pop  = (mcnt[k] > 0) && ascii_ready;
    bit drop = 1'b0;
    int ch   = -1;
    if (scan_valid) begin
      if (mplen[k] == 0) begin
        if (scan_code == 8'hE0 || scan_code == 8'hF0) begin
          mpre[k] = scan_code; mplen[k] = 1;
        end else if (scan_code == 8'h12) ml[k] = 1'b1;
        else if (scan_code == 8'h59) mr[k] = 1'b1;
        else begin
          ch = map_code(scan_code, hex, ml[k] || mr[k]);
          if (ch < 0 && err) ch = 'h78;
        end
      end else if (mplen[k] == 1 && mpre[k] == 8'hF0) begin
        if (scan_code == 8'h12) ml[k] = 1'b0;
        if (scan_code == 8'h59) mr[k] = 1'b0;
        mplen[k] = 0;
      end else if (mplen[k] == 1) begin
        mplen[k] = (scan_code == 8'hF0) ? 2 : 0;
      end else begin
        mplen[k] = 0;
      end
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mf[k][i] = mf[k][i+1];
      mcnt[k]--;
    end
    if (ch >= 0) begin
      if (mcnt[k] < DEPTH) begin
        mf[k][mcnt[k]] = ch[7:0];
        mcnt[k]++;
      end else drop = 1'b1;
    end
    if (drop) movf[k] = 1'b1;
    else if (clr_overflow) movf[k] = 1'b0;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0; ml[k] = 0; mr[k] = 0; movf[k] = 0; mplen[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.valid", k == 0 ? "a" : "b"), int'(d_valid[k]), int'(mcnt[k] > 0));
      if (mcnt[k] > 0)
        check($sformatf("%s.ascii", k == 0 ? "a" : "b"), int'(d_ascii[k]), int'(mf[k][0]));
      check($sformatf("%s.count", k == 0 ? "a" : "b"), int'(d_count[k]), mcnt[k]);
      check($sformatf("%s.shift", k == 0 ? "a" : "b"), int'(d_shift[k]), int'(ml[k] || mr[k]));
      check($sformatf("%s.ovf", k == 0 ? "a" : "b"), int'(d_ovf[k]), int'(movf[k]));
    end
  end

  task automatic tick(input logic [7:0] code, input logic v);
    scan_code  = code;
    scan_valid = v;
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic drain();
    ascii_ready  = 1'b1;
    clr_overflow = 1'b1;
    repeat (6) tick(8'h00, 1'b0);
    ascii_ready  = 1'b0;
    clr_overflow = 1'b0;
  endtask

  logic [7:0] pool [16] = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h16, 8'h1C, 8'h2B, 8'h45,
                            8'h1A, 8'h29, 8'h5A, 8'h66, 8'h0E, 8'h23, 8'h75, 8'h34};

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset.a.ascii", int'(d_ascii[0]), 0);
    check("reset.b.valid", int'(d_valid[1]), 0);
    reset = 1'b0;

    // 1: make, break -> single '1'
    tick(8'h16, 1); tick(8'hF0, 1); tick(8'h16, 1);
    check("t1.a.count", int'(d_count[0]), 1);
    check("t1.a.ascii", int'(d_ascii[0]), 'h31);
    check("t1.b.ascii", int'(d_ascii[1]), 'h31);
    drain();

    // 2: shifted / unshifted letter on full map
    tick(8'h12, 1);
    check("t2.b.shift_on", int'(d_shift[1]), 1);
    tick(8'h1C, 1); tick(8'hF0, 1); tick(8'h12, 1);
    check("t2.b.shift_off", int'(d_shift[1]), 0);
    tick(8'h1C, 1);
    check("t2.b.count", int'(d_count[1]), 2);
    check("t2.b.head0", int'(d_ascii[1]), 'h41);
    ascii_ready = 1'b1; tick(8'h00, 0); ascii_ready = 1'b0;
    check("t2.b.head1", int'(d_ascii[1]), 'h61);
    check("t2.a.head1", int'(d_ascii[0]), 'h41);
    drain();

    // 3: extended make/break ignored, then 'D'
    tick(8'hE0, 1); tick(8'h75, 1); tick(8'hE0, 1); tick(8'hF0, 1); tick(8'h75, 1);
    check("t3.a.empty", int'(d_count[0]), 0);
    tick(8'h23, 1);
    check("t3.a.ascii", int'(d_ascii[0]), 'h44);
    tick(8'h16, 1);
    check("t3.a.idle", int'(d_count[0]), 2);
    drain();

    // 4: overflow, then push+pop while full
    tick(8'h16, 1); tick(8'h1E, 1); tick(8'h26, 1); tick(8'h25, 1); tick(8'h2E, 1);
    check("t4.a.count", int'(d_count[0]), 4);
    check("t4.a.ovf", int'(d_ovf[0]), 1);
    check("t4.a.head", int'(d_ascii[0]), 'h31);
    ascii_ready = 1'b1; tick(8'h36, 1); ascii_ready = 1'b0;
    check("t4.a.count_pp", int'(d_count[0]), 4);
    check("t4.a.ovf_pp", int'(d_ovf[0]), 1);
    check("t4.a.head_pp", int'(d_ascii[0]), 'h32);
    drain();

    // 5: unmapped code
    tick(8'h0E, 1);
    check("t5.a.err", int'(d_ascii[0]), 'h78);
    check("t5.b.count", int'(d_count[1]), 0);
    drain();

    // 6: reset discards pending break
    tick(8'h12, 1); tick(8'h16, 1); tick(8'hF0, 1);
    reset = 1'b1;
    #2;
    check("t6.a.valid", int'(d_valid[0]), 0);
    check("t6.a.ascii", int'(d_ascii[0]), 0);
    check("t6.a.count", int'(d_count[0]), 0);
    check("t6.b.shift", int'(d_shift[1]), 0);
    check("t6.a.ovf", int'(d_ovf[0]), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    tick(8'h16, 1);
    check("t6.a.ascii_after", int'(d_ascii[0]), 'h31);
    check("t6.b.count_after", int'(d_count[1]), 1);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] code;
      code = (($urandom % 5) == 0) ? 8'($urandom) : pool[$urandom % 16];
      ascii_ready  = ((i / 64) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      clr_overflow = (($urandom % 16) == 0);
      if (i == 1500) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
      end
      tick(code, 1'($urandom % 2));
    end
    clr_overflow = 1'b0;
    ascii_ready  = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
